// File: rtl/aes_key_schedule.sv
// AES-128/192/256 key expansion, one 32-bit word per clock, into a round-key store
// with a registered random-access read port (one 128-bit round key per read).
module aes_key_schedule #(
  parameter int unsigned MAX_KEY_BITS = 256,
  parameter int unsigned MAX_WORDS    = 60
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         keys_ready,
  output logic         cfg_err,
  output logic [3:0]   num_rounds,
  input  logic         rd_en,
  input  logic [3:0]   rd_round,
  output logic         rd_valid,
  output logic [127:0] rd_key,
  output logic         rd_err
);

  localparam int unsigned AW = $clog2(MAX_WORDS + 1);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND} state_t;
  state_t state_q, state_d;

  logic [AW-1:0] i_q;
  logic [AW-1:0] tot_q;
  logic [2:0]    ph_q;
  logic [3:0]    nk_q;
  logic [3:0]    nr_q;
  logic [7:0]    rcon_q;
  logic [31:0]   win_q [8];
  logic          done_q, ready_q, cfg_err_q;
  logic          rd_valid_q, rd_err_q;
  logic [127:0]  rd_key_q;
  logic [31:0]   mem [MAX_WORDS];

  logic          legal, accept, reject, wr_en, finish, ph_wrap, all_written;
  int unsigned   req_bits;
  logic [31:0]   keyw [8];
  logic [31:0]   prev_w, old_w, sbox_in, sbox_out, temp, new_word;
  logic [AW-1:0] rd_base;

  always_comb begin
    req_bits = 32'd128 + 32'(key_len) * 32'd64;
    legal    = (key_len != 2'd3) && (req_bits <= MAX_KEY_BITS);
  end

  assign ph_wrap     = ({1'b0, ph_q} == (nk_q - 4'd1));
  assign all_written = (i_q == tot_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && legal) state_d = LOAD;
      LOAD:    if (ph_wrap)        state_d = EXPAND;
      EXPAND:  if (all_written)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // EXPAND spends one extra cycle after the last write so done lands one edge later.
  always_comb begin
    busy   = (state_q != IDLE);
    accept = (state_q == IDLE) && start && legal;
    reject = (state_q == IDLE) && start && !legal;
    wr_en  = (state_q == LOAD) || ((state_q == EXPAND) && !all_written);
    finish = (state_q == EXPAND) && all_written;
  end

  always_comb begin
    for (int unsigned k = 0; k < 8; k++) keyw[k] = key_in[255 - 32*k -: 32];
    prev_w   = win_q[0];
    old_w    = win_q[3'(nk_q - 4'd1)];
    sbox_in  = (ph_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
    sbox_out = sub_word(sbox_in);
    temp     = prev_w;
    if (ph_q == 3'd0)                          temp = sbox_out ^ {rcon_q, 24'h0};
    else if ((nk_q == 4'd8) && (ph_q == 3'd4)) temp = sbox_out;
    new_word = (state_q == LOAD) ? keyw[ph_q] : (old_w ^ temp);
    rd_base  = AW'({rd_round, 2'b00});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_q        <= '0;
      tot_q      <= '0;
      ph_q       <= '0;
      nk_q       <= '0;
      nr_q       <= '0;
      rcon_q     <= 8'h01;
      for (int unsigned k = 0; k < 8; k++) win_q[k] <= '0;
      done_q     <= 1'b0;
      ready_q    <= 1'b0;
      cfg_err_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_key_q   <= '0;
    end else begin
      done_q    <= finish;
      cfg_err_q <= reject;
      if (finish) ready_q <= 1'b1;
      if (accept) begin
        i_q     <= '0;
        ph_q    <= '0;
        rcon_q  <= 8'h01;
        ready_q <= 1'b0;
        case (key_len)
          2'd0:    begin nk_q <= 4'd4; nr_q <= 4'd10; tot_q <= AW'(44); end
          2'd1:    begin nk_q <= 4'd6; nr_q <= 4'd12; tot_q <= AW'(52); end
          default: begin nk_q <= 4'd8; nr_q <= 4'd14; tot_q <= AW'(60); end
        endcase
      end else if (wr_en) begin
        i_q  <= i_q + AW'(1);
        ph_q <= ph_wrap ? 3'd0 : ph_q + 3'd1;
        if ((state_q == EXPAND) && (ph_q == 3'd0)) rcon_q <= xtime(rcon_q);
        for (int unsigned k = 7; k > 0; k--) win_q[k] <= win_q[k-1];
        win_q[0] <= new_word;
      end
      rd_valid_q <= rd_en;
      rd_err_q   <= rd_en && (rd_round > nr_q);
      if (rd_en)
        rd_key_q <= (rd_round > nr_q) ? '0 :
                    {mem[rd_base], mem[rd_base + AW'(1)], mem[rd_base + AW'(2)], mem[rd_base + AW'(3)]};
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[i_q] <= new_word;
  end

  assign done       = done_q;
  assign keys_ready = ready_q;
  assign cfg_err    = cfg_err_q;
  assign num_rounds = nr_q;
  assign rd_valid   = rd_valid_q;
  assign rd_err     = rd_err_q;
  assign rd_key     = rd_key_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Bench for aes_key_schedule: FIPS-197 vectors plus random keys checked against a
// reference expansion whose S-box is derived from GF(2^8) inversion and the affine map.
module tb_aes_key_schedule;

  logic         clk, reset, start, rd_en;
  logic [1:0]   key_len;
  logic [255:0] key_in;
  logic [3:0]   rd_round, num_rounds;
  logic         busy, done, keys_ready, cfg_err, rd_valid, rd_err;
  logic [127:0] rd_key;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  sbt [256];
  logic [31:0] ew  [60];

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  aes_key_schedule #(.MAX_KEY_BITS(256), .MAX_WORDS(60)) dut (
    .clk(clk), .reset(reset), .start(start), .key_len(key_len), .key_in(key_in),
    .busy(busy), .done(done), .keys_ready(keys_ready), .cfg_err(cfg_err),
    .num_rounds(num_rounds), .rd_en(rd_en), .rd_round(rd_round),
    .rd_valid(rd_valid), .rd_key(rd_key), .rd_err(rd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] b);
    return {b[6:0], b[7]};
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, r1, r2, r3, r4;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h00;
      for (int c = 1; c < 256; c++)
        if (v != 0 && gmul(8'(v), 8'(c)) == 8'h01) inv = 8'(c);
      r1 = rotl1(inv); r2 = rotl1(r1); r3 = rotl1(r2); r4 = rotl1(r3);
      sbt[v] = inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] m_subw(input logic [31:0] w);
    return {sbt[w[31:24]], sbt[w[23:16]], sbt[w[15:8]], sbt[w[7:0]]};
  endfunction

  task automatic model_expand(input logic [255:0] key, input int len);
    int nk, total;
    logic [7:0]  rc;
    logic [31:0] t;
    logic [255:0] kk;
    nk = 4 + 2*len;
    total = 4 * (nk + 7);
    kk = key;
    for (int i = 0; i < nk; i++) begin
      ew[i] = kk[255:224];
      kk = kk << 32;
    end
    rc = 8'h01;
    for (int i = nk; i < total; i++) begin
      t = ew[i-1];
      if (i % nk == 0) begin
        t = m_subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % 8 == 4) begin
        t = m_subw(t);
      end
      ew[i] = ew[i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] m_round(input int r);
    return {ew[4*r], ew[4*r+1], ew[4*r+2], ew[4*r+3]};
  endfunction

  // ---------------- stimulus helpers (no checking inside) ----------------
  task automatic run_exp(input logic [255:0] key, input logic [1:0] len, input int restart_at,
                         input logic rd_at_start, input logic [3:0] rd_r,
                         output int done_edge, output int done_cnt,
                         output logic busy1, output logic kr1, output logic [127:0] rdk1);
    key_in = key; key_len = len; start = 1'b1; rd_en = rd_at_start; rd_round = rd_r;
    @(posedge clk); #1;
    start = 1'b0; rd_en = 1'b0;
    done_edge = -1; done_cnt = 0;
    busy1 = 1'b0; kr1 = 1'b0; rdk1 = '0;
    for (int n = 1; n <= 70; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin busy1 = busy; kr1 = keys_ready; rdk1 = rd_key; end
      if (done) begin
        done_cnt++;
        if (done_edge < 0) done_edge = n;
      end
      start = (n == restart_at);
    end
    start = 1'b0;
  endtask

  task automatic read_round(input logic [3:0] r, output logic [127:0] k, output logic v, output logic e);
    rd_en = 1'b1; rd_round = r;
    @(posedge clk); #1;
    k = rd_key; v = rd_valid; e = rd_err;
    rd_en = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; start = 1'b0; rd_en = 1'b0; rd_round = '0; key_len = '0; key_in = '0;
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++; if ({busy, done, keys_ready, cfg_err, rd_valid, rd_err} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000000", {busy, done, keys_ready, cfg_err, rd_valid, rd_err}); end
    n_checks++; if (rd_key !== 128'h0) begin
      n_fail++; $display("FAIL reset_rd_key: got %h expected 0", rd_key); end
    n_checks++; if (num_rounds !== 4'd0) begin
      n_fail++; $display("FAIL reset_num_rounds: got %0d expected 0", num_rounds); end
  endtask

  task automatic test_aes128();
    int de, dc; logic b1, k1, v, e; logic [127:0] r1, k;
    run_exp(K128, 2'd0, -1, 1'b0, 4'd0, de, dc, b1, k1, r1);
    model_expand(K128, 0);
    n_checks++; if (de !== 45 || dc !== 1) begin
      n_fail++; $display("FAIL a128_done_edge: got edge %0d count %0d expected edge 45 count 1", de, dc); end
    n_checks++; if (b1 !== 1'b1) begin
      n_fail++; $display("FAIL a128_busy_edge1: got %b expected 1", b1); end
    n_checks++; if (busy !== 1'b0 || keys_ready !== 1'b1) begin
      n_fail++; $display("FAIL a128_idle_ready: got busy %b ready %b expected 0 1", busy, keys_ready); end
    n_checks++; if (num_rounds !== 4'd10) begin
      n_fail++; $display("FAIL a128_num_rounds: got %0d expected 10", num_rounds); end
    read_round(4'd1, k, v, e);
    n_checks++; if (k !== 128'ha0fafe1788542cb123a339392a6c7605 || v !== 1'b1 || e !== 1'b0) begin
      n_fail++; $display("FAIL a128_round1: got %h v%b e%b expected a0fafe1788542cb123a339392a6c7605 v1 e0", k, v, e); end
    read_round(4'd10, k, v, e);
    n_checks++; if (k !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      n_fail++; $display("FAIL a128_round10: got %h expected d014f9a8c9ee2589e13f0cc8b6630ca6", k); end
    read_round(4'd0, k, v, e);
    n_checks++; if (k !== m_round(0)) begin
      n_fail++; $display("FAIL a128_round0: got %h expected %h", k, m_round(0)); end
  endtask

  task automatic test_illegal();
    logic v, e; logic [127:0] k;
    key_len = 2'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++; if (cfg_err !== 1'b1 || busy !== 1'b0 || keys_ready !== 1'b1) begin
      n_fail++; $display("FAIL illegal_len: got cfg_err %b busy %b ready %b expected 1 0 1", cfg_err, busy, keys_ready); end
    @(posedge clk); #1;
    n_checks++; if (cfg_err !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL illegal_pulse: got cfg_err %b busy %b expected 0 0", cfg_err, busy); end
    read_round(4'd11, k, v, e);
    n_checks++; if (e !== 1'b1 || v !== 1'b1 || k !== 128'h0) begin
      n_fail++; $display("FAIL rd_out_of_range: got err %b valid %b key %h expected 1 1 0", e, v, k); end
    @(posedge clk); #1;
    n_checks++; if (rd_valid !== 1'b0 || rd_err !== 1'b0) begin
      n_fail++; $display("FAIL rd_idle: got valid %b err %b expected 0 0", rd_valid, rd_err); end
  endtask

  task automatic test_aes192_with_read();
    int de, dc; logic b1, k1, v, e; logic [127:0] r1, k;
    run_exp(K192, 2'd1, -1, 1'b1, 4'd1, de, dc, b1, k1, r1);
    n_checks++; if (r1 !== 128'ha0fafe1788542cb123a339392a6c7605) begin
      n_fail++; $display("FAIL start_read_old: got %h expected a0fafe1788542cb123a339392a6c7605", r1); end
    n_checks++; if (k1 !== 1'b0) begin
      n_fail++; $display("FAIL start_clears_ready: got %b expected 0", k1); end
    n_checks++; if (de !== 53 || dc !== 1) begin
      n_fail++; $display("FAIL a192_done_edge: got edge %0d count %0d expected 53 1", de, dc); end
    read_round(4'd12, k, v, e);
    n_checks++; if (k !== 128'he98ba06f448c773c8ecc720401002202 || num_rounds !== 4'd12) begin
      n_fail++; $display("FAIL a192_round12: got %h nr %0d expected e98ba06f448c773c8ecc720401002202 nr 12", k, num_rounds); end
  endtask

  task automatic test_aes256();
    int de, dc; logic b1, k1, v, e; logic [127:0] r1, k;
    run_exp(K256, 2'd2, -1, 1'b0, 4'd0, de, dc, b1, k1, r1);
    model_expand(K256, 2);
    n_checks++; if (de !== 61 || dc !== 1) begin
      n_fail++; $display("FAIL a256_done_edge: got edge %0d count %0d expected 61 1", de, dc); end
    read_round(4'd14, k, v, e);
    n_checks++; if (k !== 128'hfe4890d1e6188d0b046df344706c631e) begin
      n_fail++; $display("FAIL a256_round14: got %h expected fe4890d1e6188d0b046df344706c631e", k); end
    read_round(4'd3, k, v, e);
    n_checks++; if (k !== m_round(3)) begin
      n_fail++; $display("FAIL a256_round3: got %h expected %h", k, m_round(3)); end
  endtask

  task automatic test_reset_mid();
    key_in = K256; key_len = 2'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    reset = 1'b1;
    #2;
    n_checks++; if ({busy, done, keys_ready, cfg_err, rd_valid, rd_err} !== 6'b0 || rd_key !== 128'h0 || num_rounds !== 4'd0) begin
      n_fail++; $display("FAIL reset_mid_async: got flags %b key %h nr %0d expected all 0",
                         {busy, done, keys_ready, cfg_err, rd_valid, rd_err}, rd_key, num_rounds); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0 || keys_ready !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_after: got busy %b ready %b done %b expected 0 0 0", busy, keys_ready, done); end
  endtask

  task automatic test_restart_ignored();
    int de, dc; logic b1, k1, v, e; logic [127:0] r1, k;
    run_exp(K128, 2'd0, 10, 1'b0, 4'd0, de, dc, b1, k1, r1);
    model_expand(K128, 0);
    n_checks++; if (de !== 45 || dc !== 1) begin
      n_fail++; $display("FAIL restart_ignored: got edge %0d count %0d expected 45 1", de, dc); end
    read_round(4'd10, k, v, e);
    n_checks++; if (k !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6 || keys_ready !== 1'b1) begin
      n_fail++; $display("FAIL rerun_a128_round10: got %h ready %b expected d014f9a8c9ee2589e13f0cc8b6630ca6 1", k, keys_ready); end
  endtask

  task automatic test_back_to_back();
    int de, dc, len, nr; logic b1, k1; logic [127:0] r1; logic [255:0] key;
    for (int it = 0; it < 6; it++) begin
      len = (it < 3) ? it : int'($urandom_range(0, 2));
      for (int w = 0; w < 8; w++) key[255 - 32*w -: 32] = $urandom;
      run_exp(key, 2'(len), -1, 1'b0, 4'd0, de, dc, b1, k1, r1);
      model_expand(key, len);
      nr = 10 + 2*len;
      n_checks++; if (de !== 4*(nr+1)+1 || num_rounds !== 4'(nr)) begin
        n_fail++; $display("FAIL rand_done_edge it%0d: got edge %0d nr %0d expected %0d %0d", it, de, num_rounds, 4*(nr+1)+1, nr); end
      rd_en = 1'b1; rd_round = 4'd0;
      for (int r = 0; r <= nr; r++) begin
        @(posedge clk); #1;
        n_checks++; if (rd_key !== m_round(r) || rd_valid !== 1'b1 || rd_err !== 1'b0) begin
          n_fail++; $display("FAIL rand_read it%0d r%0d: got %h v%b e%b expected %h v1 e0", it, r, rd_key, rd_valid, rd_err, m_round(r)); end
        if (r < nr) rd_round = 4'(r + 1);
        else rd_en = 1'b0;
      end
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_aes128();
    test_illegal();
    test_aes192_with_read();
    test_aes256();
    test_reset_mid();
    test_restart_ignored();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_key_schedule.md
# aes_key_schedule

Parametrised AES key-expansion engine for AES-128, AES-192 and AES-256, with the key length selected at run time per start. It expands the cipher key at one 32-bit word per clock into an internal round-key store. The store is readable by round index, so the encrypt and decrypt datapaths can fetch any round key in any order. It replaces the fixed 128-bit, counter-sequenced expander and adds a start/done handshake, a ready flag and a random-access read port.

## Interface
- MAX_KEY_BITS, 256: widest supported key. Legal values are 128, 192 and 256. Key lengths above MAX_KEY_BITS are rejected at start.
- MAX_WORDS, 60: store depth in 32-bit words. Equals 4*(Nr_max+1).
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request to begin expansion. Sampled only in IDLE.
- key_len  in  2  0=128, 1=192, 2=256, 3=illegal. Sampled with start.
- key_in  in  256  cipher key, left-justified. w[0]=key_in[255:224]; AES-128 uses [255:128]. Must stay stable from start until done.
- busy  out  1  high while in LOAD or EXPAND.
- done  out  1  one-cycle pulse after the last word is written.
- keys_ready  out  1  high from done until the next accepted start or reset.
- cfg_err  out  1  one-cycle pulse when start arrives with an illegal key_len.
- num_rounds  out  4  Nr latched at start: 10, 12 or 14.
- rd_en  in  1  round-key read request.
- rd_round  in  4  round index 0..Nr.
- rd_valid  out  1  rd_en delayed by one cycle.
- rd_key  out  128  {w[4r], w[4r+1], w[4r+2], w[4r+3]}, with w[4r] in [127:96].
- rd_err  out  1  high with rd_valid when rd_round > num_rounds. rd_key is 0 in that case.

## Operation
- FSM states: IDLE, LOAD, EXPAND.
  - IDLE→LOAD on start with legal key_len. This latches Nk (4/6/8), Nr (10/12/14) and total words T = 4*(Nr+1) (44/52/60). It also clears the word index i and sets rcon to 0x01.
  - LOAD writes w[i] = key word i, for i = 0..Nk-1, one word per cycle. LOAD→EXPAND when i = Nk-1.
  - EXPAND writes one word per cycle for i = Nk..T-1. EXPAND→IDLE after writing w[T-1]; done pulses in that transition cycle +1.
- Sliding window: an 8×32 shift register holds the last Nk words. w[i-1] and w[i-Nk] come only from the window; the store is never read during expansion.
- Per-word rule:
  - temp = w[i-1].
  - If i mod Nk = 0: temp = SubWord(RotWord(temp)) ^ {rcon, 24'h0}, then rcon = xtime(rcon). xtime is a left shift, XOR 0x1b on carry out.
  - Else if Nk = 8 and i mod 8 = 4: temp = SubWord(temp).
  - w[i] = w[i-Nk] ^ temp.
- i mod Nk comes from a 0..Nk-1 phase counter, not a divider. A single 4-byte S-box feeds both SubWord cases.
- Read port:
  - Registered, one-cycle latency, independent of the FSM.
  - Reads while busy return whatever the store currently holds. Consumers must gate on keys_ready.
- Start handling:
  - start while busy is ignored; there is no restart.
  - start with key_len=3, or above MAX_KEY_BITS, pulses cfg_err. The FSM stays in IDLE and keys_ready is unchanged.
- Accepted start clears keys_ready in the same edge.

## Timing
- Reset values: state=IDLE; busy, done, keys_ready, cfg_err, rd_valid, rd_err = 0; rd_key=0; num_rounds=0; rcon=0x01. The store is not cleared.
- Reset mid-expansion aborts immediately and keys_ready stays 0. Store contents are unspecified until the next completed expansion.
- Latency:
  - start at edge 0 → busy high from edge 1.
  - w[k] is written at edge k+1.
  - busy low and done high at edge T+1: 45, 53 or 61.
  - keys_ready is high from edge T+1.
- Read: rd_en/rd_round sampled at edge n → rd_key, rd_valid, rd_err valid after edge n+1. Back-to-back reads at one per cycle are allowed.
- Simultaneous start and rd_en in IDLE: both are accepted, and the read returns pre-start store contents.

## Test plan
- AES-128 (FIPS-197 A.1), key 2b7e151628aed2a6abf7158809cf4f3c:
  - done at edge 45.
  - rd_round=1 → a0fafe1788542cb123a339392a6c7605.
  - rd_round=10 → d014f9a8c9ee2589e13f0cc8b6630ca6.
  - num_rounds=10.
- AES-192 (A.2), key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - done at edge 53.
  - rd_round=12 → e98ba06f448c773c8ecc720401002202.
- AES-256 (A.3), key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - done at edge 61.
  - rd_round=14 → fe4890d1e6188d0b046df344706c631e.
  - Confirms the i mod 8 = 4 SubWord path.
- Illegal cases:
  - key_len=3 start → cfg_err single pulse, busy stays 0, keys_ready unchanged.
  - rd_round=11 after an AES-128 run → rd_err=1, rd_key=0.
- Reset and restart:
  - Assert reset at edge 20 of an AES-256 run → all outputs 0 next cycle, keys_ready=0.
  - Re-run A.1 → results correct.
  - start pulsed during busy is ignored: done occurs exactly once, at the original edge.
